// File: rtl/reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe
// Purpose  : N-bit, DEPTH-stage register pipeline with per-stage valid flags,
//            stall (ENABLE), synchronous flush (CLEAR) and a registered
//            occupancy count. Used as a configurable delay line / retiming
//            stage between datapath blocks on a shared clock.
// Ports    : CLOCK    - clock, all state updates on posedge
//            RESET    - asynchronous, active-low reset
//            ENABLE   - 1 = advance pipeline, 0 = hold
//            CLEAR    - synchronous flush (wins over ENABLE)
//            D/D_VALID- data and valid flag into stage 0
//            Q/Q_VALID- data and valid flag of stage DEPTH-1 (registered)
//            COUNT    - number of stages holding valid data (registered)
//            TAP_SEL/TAP_Q/TAP_VALID - stage observation mux, present only
//            when REG_PIPE_TAP_EN is defined
// Macro    : REG_PIPE_TAP_EN - adds the stage tap mux and its ports
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe #(
  parameter int           N         = 32,
  parameter int           DEPTH     = 4,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic                       CLEAR,
  input  logic [N-1:0]               D,
  input  logic                       D_VALID,
  output logic [N-1:0]               Q,
  output logic                       Q_VALID,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
`ifdef REG_PIPE_TAP_EN
  ,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] TAP_SEL,
  output logic [N-1:0]               TAP_Q,
  output logic                       TAP_VALID
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("reg_pipe: DEPTH must be at least 1");
    end
  endgenerate

  // Stage 0 is the newest entry, stage DEPTH-1 drives Q.
  logic [N-1:0]    data_q  [DEPTH];
  logic [N-1:0]    data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (CLEAR) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VAL;
      end
      valid_d = '0;
      count_d = '0;
    end else if (ENABLE) begin
      data_d[0]  = D;
      valid_d[0] = D_VALID;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Modular arithmetic: the full-pipe case (+1 then -1) wraps back
      // to DEPTH even when DEPTH+1 does not fit in CW bits.
      count_d = count_q + CW'(D_VALID) - CW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign Q       = data_q[DEPTH-1];
  assign Q_VALID = valid_q[DEPTH-1];
  assign COUNT   = count_q;

`ifdef REG_PIPE_TAP_EN
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Compare-based mux so that selects beyond DEPTH-1 simply fall through
  // to the RESET_VAL/0 default without out-of-range indexing.
  always_comb begin
    TAP_Q     = RESET_VAL;
    TAP_VALID = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (TAP_SEL == TW'(i)) begin
        TAP_Q     = data_q[i];
        TAP_VALID = valid_q[i];
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_pipe
// Purpose  : Self-checking bench for reg_pipe (N=32, DEPTH=4, RESET_VAL=0).
//            Directed vector table, scoreboard-checked random stream,
//            asynchronous mid-stream reset, and tap checks when
//            REG_PIPE_TAP_EN is defined (second instance with DEPTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_pipe;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic [N-1:0]  d;
  logic          d_valid;
  logic [N-1:0]  q;
  logic          q_valid;
  logic [CW-1:0] count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

`ifdef REG_PIPE_TAP_EN
  logic [1:0]   tap_sel;
  logic [N-1:0] tap_q;
  logic         tap_valid;
  logic [1:0]   tap_sel3;
  logic [N-1:0] tap_q3;
  logic         tap_valid3;
  logic [N-1:0] q3;
  logic         q_valid3;
  logic [1:0]   count3;
`endif

  reg_pipe #(.N(N), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
    .CLOCK   (clk),
    .RESET   (rst_n),
    .ENABLE  (en),
    .CLEAR   (clr),
    .D       (d),
    .D_VALID (d_valid),
    .Q       (q),
    .Q_VALID (q_valid),
    .COUNT   (count)
`ifdef REG_PIPE_TAP_EN
    ,
    .TAP_SEL   (tap_sel),
    .TAP_Q     (tap_q),
    .TAP_VALID (tap_valid)
`endif
  );

`ifdef REG_PIPE_TAP_EN
  reg_pipe #(.N(N), .DEPTH(3), .RESET_VAL('0)) dut3 (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .ENABLE    (en),
    .CLEAR     (clr),
    .D         (d),
    .D_VALID   (d_valid),
    .Q         (q3),
    .Q_VALID   (q_valid3),
    .COUNT     (count3),
    .TAP_SEL   (tap_sel3),
    .TAP_Q     (tap_q3),
    .TAP_VALID (tap_valid3)
  );
`endif

  typedef struct {
    logic         en;
    logic         clr;
    logic [N-1:0] d;
    logic         v;
    logic [N-1:0] q;
    logic         qv;
    int           cnt;
  } vec_t;

  typedef struct {
    logic [N-1:0] d;
    logic         v;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];   // front = stage DEPTH-1 (what Q shows), back = stage 0

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic e, input logic c, input logic [N-1:0] dd,
                              input logic v, input logic [N-1:0] eq, input logic eqv,
                              input int ecnt);
    vec_t r;
    r.en = e; r.clr = c; r.d = dd; r.v = v; r.q = eq; r.qv = eqv; r.cnt = ecnt;
    vecs.push_back(r);
  endfunction

  task automatic sb_reset();
    ent_t z;
    z.d = '0;
    z.v = 1'b0;
    sb.delete();
    for (int i = 0; i < DEPTH; i++) sb.push_back(z);
  endtask

  function automatic int sb_pop();
    int n = 0;
    foreach (sb[i]) if (sb[i].v) n++;
    return n;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_q"},     q,           32'h0);
    check({tag, "_qv"},    32'(q_valid), 32'h0);
    check({tag, "_count"}, 32'(count),  32'h0);
`ifdef REG_PIPE_TAP_EN
    check({tag, "_tapq"},  tap_q,           32'h0);
    check({tag, "_tapv"},  32'(tap_valid),  32'h0);
`endif
  endtask

  task automatic run_random(input int cycles);
    ent_t e;
    ent_t gone;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      en      = ($urandom_range(3) != 0);
      clr     = ($urandom_range(19) == 0);
      d       = $urandom;
      d_valid = 1'($urandom_range(1));
      if (clr) begin
        sb_reset();
      end else if (en) begin
        gone = sb.pop_front();
        e.d  = d;
        e.v  = d_valid;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      check("rnd_q",     q,            sb[0].d);
      check("rnd_qv",    32'(q_valid), 32'(sb[0].v));
      check("rnd_count", 32'(count),   32'(sb_pop()));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] tapv [4];
    rst_n   = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    d       = '0;
    d_valid = 1'b0;
`ifdef REG_PIPE_TAP_EN
    tap_sel  = 2'd0;
    tap_sel3 = 2'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // en, clr, d, v -> expected q, q_valid, count after the edge
    // idle with ENABLE low
    add(0, 0, 32'h0,    0, 32'h0,    0, 0);
    add(0, 0, 32'h5,    1, 32'h0,    0, 0);
    add(0, 0, 32'h0,    0, 32'h0,    0, 0);
    // two valid words then bubbles
    add(1, 0, 32'h8000, 1, 32'h0,    0, 1);
    add(1, 0, 32'h0001, 1, 32'h0,    0, 2);
    add(1, 0, 32'h0,    0, 32'h0,    0, 2);
    add(1, 0, 32'h0,    0, 32'h8000, 1, 2);
    add(1, 0, 32'h0,    0, 32'h0001, 1, 1);
    add(1, 0, 32'h0,    0, 32'h0,    0, 0);
    // empty pipe, bubble in: stays empty
    add(1, 0, 32'h0,    0, 32'h0,    0, 0);
    // fill four valid words
    add(1, 0, 32'h11,   1, 32'h0,    0, 1);
    add(1, 0, 32'h22,   1, 32'h0,    0, 2);
    add(1, 0, 32'h33,   1, 32'h0,    0, 3);
    add(1, 0, 32'h44,   1, 32'h11,   1, 4);
    // stall five cycles with junk on D
    for (int i = 0; i < 5; i++) add(0, 0, 32'hF0 + i, 1, 32'h11, 1, 4);
    // full pipe, valid in: count stays at DEPTH, oldest leaves
    add(1, 0, 32'h55,   1, 32'h22,   1, 4);
    // drain
    add(1, 0, 32'h0,    0, 32'h33,   1, 3);
    add(1, 0, 32'h0,    0, 32'h44,   1, 2);
    add(1, 0, 32'h0,    0, 32'h55,   1, 1);
    add(1, 0, 32'h0,    0, 32'h0,    0, 0);
    // refill, then flush with ENABLE and D_VALID high
    add(1, 0, 32'h66,   1, 32'h0,    0, 1);
    add(1, 0, 32'h77,   1, 32'h0,    0, 2);
    add(1, 0, 32'h88,   1, 32'h0,    0, 3);
    add(1, 0, 32'h99,   1, 32'h66,   1, 4);
    add(1, 1, 32'hAB,   1, 32'h0,    0, 0);
    // flushed word must never emerge
    for (int i = 0; i < 4; i++) add(1, 0, 32'h0, 0, 32'h0, 0, 0);
    // flush while stalled
    add(1, 0, 32'hC1,   1, 32'h0,    0, 1);
    add(0, 1, 32'hC2,   1, 32'h0,    0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 32'h0, 0, 32'h0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      en      = vecs[i].en;
      clr     = vecs[i].clr;
      d       = vecs[i].d;
      d_valid = vecs[i].v;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i),     q,            vecs[i].q);
      check($sformatf("vec%0d_qv", i),    32'(q_valid), 32'(vecs[i].qv));
      check($sformatf("vec%0d_count", i), 32'(count),   vecs[i].cnt);
    end

    // table ends with an all-bubble pipe
    sb_reset();
    run_random(60);

    // asynchronous reset between edges, held across one edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    en      = 1'b1;
    clr     = 1'b0;
    d_valid = 1'b1;
    d       = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_idle("rst_held");
    @(negedge clk);
    en      = 1'b0;
    d_valid = 1'b0;
    rst_n   = 1'b1;
    sb_reset();
    run_random(60);

`ifdef REG_PIPE_TAP_EN
    tapv[0] = 32'hA;
    tapv[1] = 32'hB;
    tapv[2] = 32'hC;
    tapv[3] = 32'hD;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en      = 1'b1;
      clr     = 1'b0;
      d       = tapv[k];
      d_valid = 1'b1;
    end
    @(negedge clk);
    en      = 1'b0;
    d_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tap_sel = 2'(s);
      #1;
      check($sformatf("tap%0d_q", s), tap_q,           tapv[3-s]);
      check($sformatf("tap%0d_v", s), 32'(tap_valid),  32'h1);
    end
    tap_sel3 = 2'd2;
    #1;
    check("tap3_sel2_q", tap_q3,           32'hB);
    check("tap3_sel2_v", 32'(tap_valid3),  32'h1);
    tap_sel3 = 2'd3;
    #1;
    check("tap3_sel3_q", tap_q3,           32'h0);
    check("tap3_sel3_v", 32'(tap_valid3),  32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
